// File: rtl/dlx_global_pkg.sv
// Shared constants and types for the DLX memory-side blocks.
package dlx_global_pkg;

  localparam int unsigned MEM_WIDTH    = 32;
  localparam int unsigned bw_cacheline = 128;
  localparam int unsigned LINE_WORDS   = bw_cacheline / MEM_WIDTH;
  localparam int unsigned CNT_W        = 2;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned OFFS_W       = 4;
  localparam int unsigned BASE_W       = ADDR_W - OFFS_W;

  // Requester indices into the arbiter request/grant vectors.
  localparam int unsigned REQ_IC = 0;
  localparam int unsigned REQ_DC = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_BURST = 2'd1,
    DC_BURST = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dlx_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not last served.
module dlx_rr_arb2
  import dlx_global_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_dc,
  output logic [1:0] gnt_c
);

  // One-hot grant; bit REQ_IC = I-cache, bit REQ_DC = D-cache.
  always_comb begin
    gnt_c = 2'b00;
    if (req[REQ_IC] && req[REQ_DC]) begin
      gnt_c[REQ_DC] = ~last_dc;
      gnt_c[REQ_IC] = last_dc;
    end else begin
      gnt_c = req;
    end
  end

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates I-cache and D-cache line bursts onto a single-word main-memory port.
module dlx_mem_arbiter
  import dlx_global_pkg::*;
#(
  parameter int unsigned WORD_W = MEM_WIDTH,
  parameter int unsigned LINE_W = bw_cacheline
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [31:0]       ic_addr,
  output logic              ic_rvalid,
  output logic [WORD_W-1:0] ic_rdata,
  output logic [1:0]        ic_widx,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [31:0]       dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_rvalid,
  output logic [WORD_W-1:0] dc_rdata,
  output logic [1:0]        dc_widx,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  arb_state_e        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [BASE_W-1:0] base_q, base_n;
  logic              we_q, we_n;
  logic [LINE_W-1:0] line_q, line_n;
  logic              last_dc_q, last_dc_n;
  logic              burst_end;
  logic [1:0]        gnt;

  logic              mem_req_d, mem_we_d;
  logic [31:0]       mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_d;
  logic              ic_rvalid_d, ic_done_d, dc_rvalid_d, dc_done_d;
  logic [WORD_W-1:0] ic_rdata_d, dc_rdata_d;
  logic [1:0]        ic_widx_d, dc_widx_d;

  // Line offset bits are dropped: bursts always start at the line base.
  logic unused_offs;
  assign unused_offs = ^{ic_addr[OFFS_W-1:0], dc_addr[OFFS_W-1:0]};

  dlx_rr_arb2 u_rr_arb2 (
    .req     ({dc_req, ic_req}),
    .last_dc (last_dc_q),
    .gnt_c   (gnt)
  );

  // State register with grant latch, word counter and last-served flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      we_q      <= 1'b0;
      line_q    <= '0;
      last_dc_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      base_q    <= base_n;
      we_q      <= we_n;
      line_q    <= line_n;
      last_dc_q <= last_dc_n;
    end
  end

  // Next state: grant only from IDLE, advance on each ack, leave after the last word.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    base_n    = base_q;
    we_n      = we_q;
    line_n    = line_q;
    last_dc_n = last_dc_q;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (gnt[REQ_DC]) begin
          state_n = DC_BURST;
          base_n  = dc_addr[ADDR_W-1:OFFS_W];
          we_n    = dc_we;
          line_n  = dc_wdata;
        end else if (gnt[REQ_IC]) begin
          state_n = IC_BURST;
          base_n  = ic_addr[ADDR_W-1:OFFS_W];
          we_n    = 1'b0;
          line_n  = '0;
        end
      end
      IC_BURST, DC_BURST: begin
        if (mem_ack) begin
          cnt_n = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_WORD) begin
            burst_end = 1'b1;
            state_n   = IDLE;
            last_dc_n = (state_q == DC_BURST);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output next values, derived from next state so the memory port tracks cnt without a bubble.
  always_comb begin
    mem_req_d   = (state_n != IDLE);
    mem_we_d    = (state_n == DC_BURST) && we_n;
    mem_addr_d  = mem_req_d ? {base_n, cnt_n, 2'b00} : 32'h0;
    mem_wdata_d = '0;
    for (int w = 0; w < int'(LINE_WORDS); w++) begin
      if (mem_we_d && (cnt_n == CNT_W'(w))) begin
        mem_wdata_d = line_n[w*WORD_W +: WORD_W];
      end
    end
    ic_rvalid_d = mem_ack && (state_q == IC_BURST);
    ic_rdata_d  = ic_rvalid_d ? mem_rdata : '0;
    ic_widx_d   = ic_rvalid_d ? cnt_q : '0;
    ic_done_d   = burst_end && (state_q == IC_BURST);
    dc_rvalid_d = mem_ack && (state_q == DC_BURST) && !we_q;
    dc_rdata_d  = dc_rvalid_d ? mem_rdata : '0;
    dc_widx_d   = dc_rvalid_d ? cnt_q : '0;
    dc_done_d   = burst_end && (state_q == DC_BURST);
  end

  // Output registers; reset clears every output at once, aborting any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_rvalid <= 1'b0;
      ic_rdata  <= '0;
      ic_widx   <= '0;
      ic_done   <= 1'b0;
      dc_rvalid <= 1'b0;
      dc_rdata  <= '0;
      dc_widx   <= '0;
      dc_done   <= 1'b0;
    end else begin
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      ic_rvalid <= ic_rvalid_d;
      ic_rdata  <= ic_rdata_d;
      ic_widx   <= ic_widx_d;
      ic_done   <= ic_done_d;
      dc_rvalid <= dc_rvalid_d;
      dc_rdata  <= dc_rdata_d;
      dc_widx   <= dc_widx_d;
      dc_done   <= dc_done_d;
    end
  end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed bench for dlx_mem_arbiter: vector table plus multi-cycle corner sequences.
module tb_dlx_mem_arbiter;

  localparam int unsigned OW = 138;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req, dc_req, dc_we, mem_ack;
  logic [31:0]  ic_addr, dc_addr, mem_rdata;
  logic [127:0] dc_wdata;
  logic         ic_rvalid, ic_done, dc_rvalid, dc_done;
  logic [31:0]  ic_rdata, dc_rdata;
  logic [1:0]   ic_widx, dc_widx;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          icr;
    logic          dcr;
    logic          we;
    logic          ack;
    logic [31:0]   rd;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t tv [12];

  dlx_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .ic_widx(ic_widx), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_widx(dc_widx), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] pk(
    input logic mreq, input logic mwe, input logic [31:0] maddr, input logic [31:0] mwd,
    input logic icv, input logic [31:0] icd, input logic [1:0] icw, input logic icdn,
    input logic dcv, input logic [31:0] dcd, input logic [1:0] dcw, input logic dcdn);
    return {mreq, mwe, maddr, mwd, icv, icd, icw, icdn, dcv, dcd, dcw, dcdn};
  endfunction

  // Observed outputs; address and read data only matter while qualified.
  function automatic logic [OW-1:0] act();
    return pk(mem_req, mem_we, mem_req ? mem_addr : 32'h0, mem_wdata,
              ic_rvalid, ic_rvalid ? ic_rdata : 32'h0, ic_rvalid ? ic_widx : 2'd0, ic_done,
              dc_rvalid, dc_rvalid ? dc_rdata : 32'h0, dc_rvalid ? dc_widx : 2'd0, dc_done);
  endfunction

  function automatic logic [OW-1:0] act_raw();
    return pk(mem_req, mem_we, mem_addr, mem_wdata, ic_rvalid, ic_rdata, ic_widx, ic_done,
              dc_rvalid, dc_rdata, dc_widx, dc_done);
  endfunction

  task automatic check(input string name, input logic [OW-1:0] a, input logic [OW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic drv(input logic icr, input logic dcr, input logic we, input logic ack,
                     input logic [31:0] rd);
    ic_req = icr; dc_req = dcr; dc_we = we; mem_ack = ack; mem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic setv(input int i, input logic icr, input logic dcr, input logic we,
                      input logic ack, input logic [31:0] rd, input logic [OW-1:0] e);
    tv[i].icr = icr; tv[i].dcr = dcr; tv[i].we = we; tv[i].ack = ack; tv[i].rd = rd; tv[i].exp = e;
  endtask

  localparam logic [OW-1:0] ZERO = '0;

  initial begin
    // IC refill from 0x1234 with ack every cycle, then a DC write-back to 0x8008.
    setv(0,  1, 0, 0, 0, 32'h0,         pk(1, 0, 32'h1230, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    setv(1,  1, 0, 0, 1, 32'hA0A0_0000, pk(1, 0, 32'h1234, 0, 1, 32'hA0A0_0000, 0, 0, 0, 0, 0, 0));
    setv(2,  1, 0, 0, 1, 32'hA0A0_0001, pk(1, 0, 32'h1238, 0, 1, 32'hA0A0_0001, 1, 0, 0, 0, 0, 0));
    setv(3,  1, 0, 0, 1, 32'hA0A0_0002, pk(1, 0, 32'h123C, 0, 1, 32'hA0A0_0002, 2, 0, 0, 0, 0, 0));
    setv(4,  1, 0, 0, 1, 32'hA0A0_0003, pk(0, 0, 32'h0,    0, 1, 32'hA0A0_0003, 3, 1, 0, 0, 0, 0));
    setv(5,  0, 0, 0, 0, 32'h0,         ZERO);
    setv(6,  0, 1, 1, 0, 32'h0,         pk(1, 1, 32'h8000, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 0));
    setv(7,  0, 1, 1, 1, 32'hDEAD_BEEF, pk(1, 1, 32'h8004, 32'h22222222, 0, 0, 0, 0, 0, 0, 0, 0));
    setv(8,  0, 1, 1, 1, 32'hDEAD_BEEF, pk(1, 1, 32'h8008, 32'h33333333, 0, 0, 0, 0, 0, 0, 0, 0));
    setv(9,  0, 1, 1, 1, 32'hDEAD_BEEF, pk(1, 1, 32'h800C, 32'h44444444, 0, 0, 0, 0, 0, 0, 0, 0));
    setv(10, 0, 1, 1, 1, 32'hDEAD_BEEF, pk(0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 1));
    setv(11, 0, 0, 0, 0, 32'h0,         ZERO);

    rst_n = 1'b0;
    ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0; mem_rdata = 0;
    ic_addr = 32'h0000_1234; dc_addr = 32'h0000_8008;
    dc_wdata = 128'h44444444_33333333_22222222_11111111;
    @(negedge clk); @(negedge clk);
    check("reset_outputs", act_raw(), ZERO);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", act_raw(), ZERO);

    for (int i = 0; i < 12; i++) begin
      drv(tv[i].icr, tv[i].dcr, tv[i].we, tv[i].ack, tv[i].rd);
      check($sformatf("vec%0d", i), act(), tv[i].exp);
    end

    // Tie with DC last served: IC must win.
    drv(1, 1, 0, 0, 0);
    check("tie_last_dc_gives_ic", act(), pk(1, 0, 32'h1230, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int w = 0; w < 4; w++) begin
      drv(w != 3, w != 3, 0, 1, 32'hB000_0000 + 32'(w));
      if (w < 3)
        check($sformatf("tie_word%0d", w), act(),
              pk(1, 0, 32'h1230 + 32'(4*(w+1)), 0, 1, 32'hB000_0000 + 32'(w), 2'(w), 0, 0, 0, 0, 0));
      else
        check("tie_done", act(), pk(0, 0, 0, 0, 1, 32'hB000_0003, 3, 1, 0, 0, 0, 0));
    end
    drv(0, 0, 0, 0, 0);
    check("tie_idle", act(), ZERO);

    // Slow memory (3 wait cycles per word); requester drops after first ack.
    ic_addr = 32'h2000_004C;
    drv(1, 0, 0, 0, 0);
    check("slow_grant", act(), pk(1, 0, 32'h2000_0040, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int w = 0; w < 4; w++) begin
      for (int d = 0; d < 3; d++) begin
        drv(w == 0, 0, 0, 0, 0);
        check($sformatf("slow_hold_w%0d_d%0d", w, d), act(),
              pk(1, 0, 32'h2000_0040 + 32'(4*w), 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      drv(w == 0, 0, 0, 1, 32'hC0DE_0000 + 32'(w));
      if (w < 3)
        check($sformatf("slow_ack%0d", w), act(),
              pk(1, 0, 32'h2000_0040 + 32'(4*(w+1)), 0, 1, 32'hC0DE_0000 + 32'(w), 2'(w), 0, 0, 0, 0, 0));
      else
        check("slow_done", act(), pk(0, 0, 0, 0, 1, 32'hC0DE_0003, 3, 1, 0, 0, 0, 0));
    end
    drv(0, 0, 0, 1, 32'hFFFF_FFFF);
    check("spurious_ack0", act(), ZERO);
    drv(0, 0, 0, 1, 32'hFFFF_FFFF);
    check("spurious_ack1", act(), ZERO);
    drv(0, 0, 0, 0, 0);
    check("spurious_after", act(), ZERO);

    // Reset mid-burst after the second ack.
    ic_addr = 32'h0000_3000;
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 1, 32'hE000_0000);
    drv(1, 0, 0, 1, 32'hE000_0001);
    check("pre_reset_word1", act(), pk(1, 0, 32'h3008, 0, 1, 32'hE000_0001, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", act_raw(), ZERO);
    ic_req = 0; mem_ack = 0;
    @(negedge clk); @(negedge clk);
    check("reset_held", act_raw(), ZERO);
    rst_n = 1'b1;
    dc_addr = 32'h0000_5550;
    drv(0, 0, 0, 0, 0);
    check("post_reset_idle_no_done", act_raw(), ZERO);

    // Fresh tie after reset: DC first (read), then IC.
    drv(1, 1, 0, 0, 0);
    check("reset_tie_dc_first", act(), pk(1, 0, 32'h5550, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int w = 0; w < 4; w++) begin
      drv(1, w != 3, 0, 1, 32'hD000_0000 + 32'(w));
      if (w < 3)
        check($sformatf("dc_read%0d", w), act(),
              pk(1, 0, 32'h5550 + 32'(4*(w+1)), 0, 0, 0, 0, 0, 1, 32'hD000_0000 + 32'(w), 2'(w), 0));
      else
        check("dc_read_done", act(), pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hD000_0003, 3, 1));
    end
    drv(1, 0, 0, 0, 0);
    check("ic_after_dc", act(), pk(1, 0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int w = 0; w < 4; w++) begin
      drv(w != 3, 0, 0, 1, 32'hF000_0000 + 32'(w));
      if (w < 3)
        check($sformatf("ic2_word%0d", w), act(),
              pk(1, 0, 32'h3000 + 32'(4*(w+1)), 0, 1, 32'hF000_0000 + 32'(w), 2'(w), 0, 0, 0, 0, 0));
      else
        check("ic2_done", act(), pk(0, 0, 0, 0, 1, 32'hF000_0003, 3, 1, 0, 0, 0, 0));
    end
    drv(0, 0, 0, 0, 0);
    check("final_idle", act(), ZERO);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlx_mem_arbiter.md
DLX_MEM_ARBITER -- requirements
Module: dlx_mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, memory/requester word width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width; LINE_WORDS = LINE_W/WORD_W = 4.
REQ-003 SHALL have ports, in this order: clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ic_req  in  1  I-cache line refill request, level, held until ic_done.
REQ-006 ic_addr  in  32  I-cache miss address.
REQ-007 ic_rvalid  out  1  refill word valid; ic_rdata  out  WORD_W  word; ic_widx  out  2  word index.
REQ-008 ic_done  out  1  one-cycle pulse, I-cache burst complete.
REQ-009 dc_req  in  1  D-cache request, level; dc_we  in  1  1=line write-back, 0=refill.
REQ-010 dc_addr  in  32  D-cache address; dc_wdata  in  LINE_W  write-back line, word 0 in bits [31:0].
REQ-011 dc_rvalid  out  1; dc_rdata  out  WORD_W; dc_widx  out  2; dc_done  out  1, as the I-cache equivalents.
REQ-012 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  WORD_W; single-word main-memory port.
REQ-013 mem_rdata  in  WORD_W; mem_ack  in  1  word accepted/returned; variable latency, zero or more cycles after mem_req.

Function
REQ-014 SHALL implement states IDLE, IC_BURST, DC_BURST.
REQ-015 Requests SHALL be sampled only in IDLE; IDLE->IC_BURST or DC_BURST on the next edge.
REQ-016 Only one requester asserting SHALL be granted; both asserting SHALL grant the one not last served (round-robin).
REQ-017 Grant latch SHALL capture line base = addr[31:4] with [3:0] = 0, plus dc_we and dc_wdata (DC grants only).
REQ-018 mem_req SHALL be 1 throughout a BURST state; mem_addr = base + 4*cnt; mem_we = captured dc_we in DC_BURST, else 0.
REQ-019 mem_wdata SHALL equal word cnt of the captured line during a DC write, else 0.
REQ-020 Word counter cnt (2 bits) SHALL be 0 at burst start and increment on each mem_ack.
REQ-021 On read-burst mem_ack, the granted side SHALL show rvalid=1, rdata=mem_rdata, widx=cnt on the next cycle (registered).
REQ-022 On mem_ack with cnt=3, the granted side's done SHALL pulse the next cycle; FSM SHALL return to IDLE and update last-served.
REQ-023 Writes SHALL assert dc_done only, with no dc_rvalid.
REQ-024 At least one IDLE cycle SHALL separate consecutive bursts; no back-to-back grant.
REQ-025 Requester deassertion mid-burst SHALL be ignored; the burst completes.
REQ-026 Changes to addr/wdata after grant SHALL NOT affect the burst.
REQ-027 mem_ack outside a BURST state SHALL be ignored.
REQ-028 Burst latency with ack every cycle SHALL be grant + 4 cycles to the done pulse.

Reset
REQ-029 rst_n=0 SHALL force IDLE, cnt=0, and all outputs 0 immediately, including mid-burst (burst aborted, no done).
REQ-030 Reset SHALL set last-served = IC, so DC wins the first tie.

Structure
REQ-031 State enum, line-word count, and MEM_WIDTH/bw_cacheline constants SHALL reside in dlx_global_pkg.
REQ-032 Round-robin pick SHALL be sub-module dlx_rr_arb2 (2 requests, last-served input, one-hot grant).
REQ-033 Design SHALL be fully synchronous to clk except the async reset; no combinational in-to-out path.

Verification
REQ-034 After reset, dc_req=1 ic_req=1 together -> DC granted first; after dc_done, IC granted next.
REQ-035 ic_req, addr 0x0000_1234, mem_ack every cycle -> mem_addr 0x1230,0x1234,0x1238,0x123C; ic_widx 0..3; ic_done 4 cycles after grant.
REQ-036 dc_we=1, dc_wdata=0x44..._33..._22..._11... -> mem_wdata 0x11111111,0x22222222,0x33333333,0x44444444 with mem_we=1; no dc_rvalid.
REQ-037 mem_ack delayed 3 cycles per word -> mem_addr held stable until each ack; done after the 4th ack only.
REQ-038 rst_n low after the 2nd ack -> all outputs 0 asynchronously; after release, state IDLE and a fresh request starts at cnt=0.
REQ-039 ic_req dropped after the 1st ack, spurious mem_ack in IDLE -> burst still completes 4 words; spurious ack ignored.
